// File: rtl/pedestrian_phase_controller.sv
// Pedestrian crossing sequencer: latches button presses, requests the crossing
// from the intersection controller, then runs WALK -> flashing DON'T WALK ->
// clearance -> holdoff. All outputs are registered.
module pedestrian_phase_controller #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned MS_CONV       = 1000,
    parameter int unsigned WALK_MS       = 7000,
    parameter int unsigned CAUTION_MS    = 10000,
    parameter int unsigned CLEAR_MS      = 2000,
    parameter int unsigned HOLDOFF_MS    = 20000,
    parameter int unsigned FLASH_HALF_MS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ped_button,
    input  logic        ped_grant,
    input  logic        ped_abort,
    output logic        ped_req,
    output logic        ped_done,
    output logic        walk_lamp,
    output logic        dont_walk_lamp,
    output logic        req_pending,
    output logic        pd_caution,
    output logic [31:0] pd_counter,
    output logic [31:0] pd_total_cycles,
    output logic [31:0] pd_free_cycles
);

    // Cycle counts, all in 32-bit unsigned arithmetic.
    localparam logic [31:0] CYC_MS         = 32'(CLK_FREQ / MS_CONV);
    localparam logic [31:0] FREE_CYC       = 32'(WALK_MS * CYC_MS);
    localparam logic [31:0] TOTAL_CYC      = 32'((WALK_MS + CAUTION_MS) * CYC_MS);
    localparam logic [31:0] CLEAR_CYC      = 32'(CLEAR_MS * CYC_MS);
    localparam logic [31:0] HOLDOFF_CYC    = 32'(HOLDOFF_MS * CYC_MS);
    localparam logic [31:0] FLASH_HALF_CYC = 32'(FLASH_HALF_MS * CYC_MS);

    // A zero-length phase would make the sequencer skip or stall a state.
    if (MS_CONV == 0 || CYC_MS == 0 || WALK_MS == 0 || CAUTION_MS == 0 ||
        CLEAR_MS == 0 || HOLDOFF_MS == 0 || FLASH_HALF_MS == 0) begin : g_bad_param
        $error("pedestrian_phase_controller: zero-length timing parameter");
    end

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_WALK    = 3'd2;
    localparam logic [2:0] S_FLASH   = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;
    localparam logic [2:0] S_HOLDOFF = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic        req_q, req_d;
    logic        done_q, done_d;
    logic        walk_q, walk_d;
    logic        dw_q, dw_d;
    logic        pend_q, pend_d;
    logic        caution_q, caution_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmr_q, tmr_d;   // flash half-period, clearance and holdoff timer
    logic        btn_edge;

    assign btn_edge = sync2_q & ~prev_q;

    // Next-state and registered-output computation for the crossing sequence.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        done_d    = 1'b0;
        walk_d    = walk_q;
        dw_d      = dw_q;
        pend_d    = pend_q;
        caution_d = caution_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        // Presses while the walk lamp is lit are already being served.
        if (btn_edge && state_q != S_WALK) begin
            pend_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (btn_edge) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (ped_abort) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end else if (ped_grant) begin
                    state_d   = S_WALK;
                    walk_d    = 1'b1;
                    dw_d      = 1'b0;
                    caution_d = 1'b1;
                    cnt_d     = '0;
                    pend_d    = 1'b0;   // a press on this very edge is dropped
                end
            end
            S_WALK: begin
                if (cnt_q == FREE_CYC - 32'd1 || ped_abort || !ped_grant) begin
                    state_d = S_FLASH;
                    walk_d  = 1'b0;
                    dw_d    = 1'b1;
                    cnt_d   = FREE_CYC;
                    tmr_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_FLASH: begin
                if (cnt_q == TOTAL_CYC - 32'd1) begin
                    state_d   = S_CLEAR;
                    caution_d = 1'b0;
                    dw_d      = 1'b1;
                    cnt_d     = '0;
                    tmr_d     = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (tmr_q == FLASH_HALF_CYC - 32'd1) begin
                        dw_d  = ~dw_q;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + 32'd1;
                    end
                end
            end
            S_CLEAR: begin
                if (tmr_q == CLEAR_CYC - 32'd1) begin
                    state_d = S_HOLDOFF;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            S_HOLDOFF: begin
                if (tmr_q == HOLDOFF_CYC - 32'd1) begin
                    tmr_d = '0;
                    if (pend_q || btn_edge) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                req_d     = 1'b0;
                walk_d    = 1'b0;
                dw_d      = 1'b1;
                caution_d = 1'b0;
                cnt_d     = '0;
                tmr_d     = '0;
            end
        endcase
    end

    // State, synchroniser and output registers; reset forces the safe lamp state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            walk_q    <= 1'b0;
            dw_q      <= 1'b1;
            pend_q    <= 1'b0;
            caution_q <= 1'b0;
            cnt_q     <= '0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= ped_button;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            req_q     <= req_d;
            done_q    <= done_d;
            walk_q    <= walk_d;
            dw_q      <= dw_d;
            pend_q    <= pend_d;
            caution_q <= caution_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
        end
    end

    assign ped_req         = req_q;
    assign ped_done        = done_q;
    assign walk_lamp       = walk_q;
    assign dont_walk_lamp  = dw_q;
    assign req_pending     = pend_q;
    assign pd_caution      = caution_q;
    assign pd_counter      = cnt_q;
    assign pd_total_cycles = TOTAL_CYC;
    assign pd_free_cycles  = FREE_CYC;

endmodule

// File: tb/tb_pedestrian_phase_controller.sv
// Bench for pedestrian_phase_controller: per-cycle expected outputs are queued
// as inputs are driven and compared one cycle later, just after the clock edge.
module tb_pedestrian_phase_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ped_button = 1'b0;
    logic        ped_grant = 1'b0;
    logic        ped_abort = 1'b0;
    logic        ped_req, ped_done, walk_lamp, dont_walk_lamp, req_pending, pd_caution;
    logic [31:0] pd_counter, pd_total_cycles, pd_free_cycles;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        string       tag;
        logic [37:0] v;
    } sb_ent_t;

    sb_ent_t     sb_q[$];
    sb_ent_t     ent;
    logic [37:0] obs;

    always #5 clk = ~clk;

    pedestrian_phase_controller #(
        .CLK_FREQ     (1000),
        .MS_CONV      (1000),
        .WALK_MS      (5),
        .CAUTION_MS   (4),
        .CLEAR_MS     (2),
        .HOLDOFF_MS   (3),
        .FLASH_HALF_MS(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ped_button     (ped_button),
        .ped_grant      (ped_grant),
        .ped_abort      (ped_abort),
        .ped_req        (ped_req),
        .ped_done       (ped_done),
        .walk_lamp      (walk_lamp),
        .dont_walk_lamp (dont_walk_lamp),
        .req_pending    (req_pending),
        .pd_caution     (pd_caution),
        .pd_counter     (pd_counter),
        .pd_total_cycles(pd_total_cycles),
        .pd_free_cycles (pd_free_cycles)
    );

    assign obs = {ped_req, ped_done, walk_lamp, dont_walk_lamp, req_pending, pd_caution, pd_counter};

    function automatic logic [37:0] pack(input bit rq, input bit dn, input bit wk, input bit dw,
                                         input bit pn, input bit ca, input logic [31:0] cnt);
        return {rq, dn, wk, dw, pn, ca, cnt};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s val=%h", tag, got);
        end
    endtask

    // Scoreboard consumer: one comparison per queued cycle.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            check_eq(ent.tag, {26'd0, obs}, {26'd0, ent.v});
        end
    end

    task automatic step(input bit b, input bit g, input bit a, input string tag, input logic [37:0] e);
        @(negedge clk);
        ped_button = b;
        ped_grant  = g;
        ped_abort  = a;
        sb_q.push_back('{tag: tag, v: e});
    endtask

    // One-cycle press from IDLE; the request appears after the third edge.
    task automatic press_to_wait(input string tg, input bit g, input bit pidle);
        step(1'b1, g, 1'b0, {tg, "_i0"}, pack(0, 0, 0, 1, pidle, 0, 0));
        step(1'b0, g, 1'b0, {tg, "_i1"}, pack(0, 0, 0, 1, pidle, 0, 0));
        step(1'b0, g, 1'b0, {tg, "_req"}, pack(1, 0, 0, 1, 1, 0, 0));
    endtask

    task automatic walk_steps(input string tg, input int from, input int to);
        for (int k = from; k <= to; k++)
            step(1'b0, 1'b1, 1'b0, $sformatf("%s_w%0d", tg, k), pack(1, 0, 1, 0, 0, 1, k));
    endtask

    // With noise set, abort is raised from the last WALK count and abort/grant-low
    // are then held into FLASH, where they must have no effect.
    task automatic flash_steps(input string tg, input bit noise);
        for (int k = 5; k <= 8; k++)
            step(1'b0, !(noise && k > 5 && k < 8), noise && k < 8,
                 $sformatf("%s_f%0d", tg, k), pack(1, 0, 0, (k < 7), 0, 1, k));
    endtask

    task automatic clear_hold(input string tg, input bit pend);
        step(1'b0, 1'b1, 1'b0, {tg, "_c0"}, pack(1, 0, 0, 1, pend, 0, 0));
        step(1'b0, 1'b1, 1'b0, {tg, "_c1"}, pack(1, 0, 0, 1, pend, 0, 0));
        step(1'b0, 1'b1, 1'b0, {tg, "_done"}, pack(0, 1, 0, 1, pend, 0, 0));
        step(1'b0, 1'b1, 1'b0, {tg, "_h1"}, pack(0, 0, 0, 1, pend, 0, 0));
        step(1'b0, 1'b1, 1'b0, {tg, "_h2"}, pack(0, 0, 0, 1, pend, 0, 0));
        step(1'b0, 1'b1, 1'b0, {tg, "_end"},
             pend ? pack(1, 0, 0, 1, 1, 0, 0) : pack(0, 0, 0, 1, 0, 0, 0));
    endtask

    task automatic tail(input string tg, input int from);
        walk_steps(tg, from, 4);
        flash_steps(tg, 1'b0);
        clear_hold(tg, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {26'd0, obs}, {26'd0, pack(0, 0, 0, 1, 0, 0, 0)});
        check_eq("total_cycles", {32'd0, pd_total_cycles}, 64'd9);
        check_eq("free_cycles", {32'd0, pd_free_cycles}, 64'd5);
        rst_n = 1'b1;

        // 1: grant tied high, full crossing.
        press_to_wait("s1", 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, "s1_w0", pack(1, 0, 1, 0, 0, 1, 0));
        tail("s1", 1);

        // 2: grant withheld for 20 cycles.
        press_to_wait("s2", 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b0, $sformatf("s2_hold%0d", i), pack(1, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b1, 1'b0, "s2_w0", pack(1, 0, 1, 0, 0, 1, 0));
        tail("s2", 1);

        // 3: abort at pd_counter=2 cuts WALK short.
        press_to_wait("s3", 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, "s3_w0", pack(1, 0, 1, 0, 0, 1, 0));
        walk_steps("s3", 1, 2);
        flash_steps("s3", 1'b1);
        clear_hold("s3", 1'b0);

        // 4: press in FLASH re-requests after holdoff; press in WALK is ignored.
        press_to_wait("s4", 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, "s4_w0", pack(1, 0, 1, 0, 0, 1, 0));
        walk_steps("s4", 1, 4);
        step(1'b1, 1'b1, 1'b0, "s4_f5", pack(1, 0, 0, 1, 0, 1, 5));
        step(1'b0, 1'b1, 1'b0, "s4_f6", pack(1, 0, 0, 1, 0, 1, 6));
        step(1'b0, 1'b1, 1'b0, "s4_f7", pack(1, 0, 0, 0, 1, 1, 7));
        step(1'b0, 1'b1, 1'b0, "s4_f8", pack(1, 0, 0, 0, 1, 1, 8));
        clear_hold("s4", 1'b1);
        step(1'b1, 1'b1, 1'b0, "s4b_w0", pack(1, 0, 1, 0, 0, 1, 0));
        tail("s4b", 1);

        // 5: asynchronous reset in FLASH.
        press_to_wait("s5", 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, "s5_w0", pack(1, 0, 1, 0, 0, 1, 0));
        walk_steps("s5", 1, 4);
        step(1'b0, 1'b1, 1'b0, "s5_f5", pack(1, 0, 0, 1, 0, 1, 5));
        step(1'b0, 1'b1, 1'b0, "s5_f6", pack(1, 0, 0, 1, 0, 1, 6));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("s5_async_rst", {26'd0, obs}, {26'd0, pack(0, 0, 0, 1, 0, 0, 0)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("s5_rst_hold%0d", i), {26'd0, obs}, {26'd0, pack(0, 0, 0, 1, 0, 0, 0)});
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, "s5_idle0", pack(0, 0, 0, 1, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, "s5_idle1", pack(0, 0, 0, 1, 0, 0, 0));

        // 6a: two presses while waiting give one crossing.
        press_to_wait("s6", 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, "s6_wa", pack(1, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, "s6_wb", pack(1, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, "s6_wc", pack(1, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, "s6_wd", pack(1, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b1, 1'b0, "s6_w0", pack(1, 0, 1, 0, 0, 1, 0));
        tail("s6", 1);
        step(1'b0, 1'b1, 1'b0, "s6_idle0", pack(0, 0, 0, 1, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0, "s6_idle1", pack(0, 0, 0, 1, 0, 0, 0));

        // 6b: abort (together with grant) while waiting returns to IDLE, press kept.
        press_to_wait("s6x", 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "s6x_wait", pack(1, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b1, 1'b1, "s6x_abort", pack(0, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, "s6x_idle0", pack(0, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, "s6x_idle1", pack(0, 0, 0, 1, 1, 0, 0));

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
